// File: rtl/sgd_gradient_batch_acc.sv
// sgd_gradient_batch_acc: mini-batch gradient accumulator with RAM partial sums and step-scaled output.
// Define SGD_ACC_SATURATE_EN for a saturating per-lane add; otherwise the add wraps.
module sgd_gradient_batch_acc #(
  parameter int LANES = 8,
  parameter int DEPTH_BITS = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  started,
  input  logic [DEPTH_BITS:0]   num_chunks,
  input  logic [15:0]           batch_size,
  input  logic [4:0]            step_shift,
  input  logic [LANES*32-1:0]   grad_in,
  input  logic                  grad_valid,
  output logic [LANES*32-1:0]   acc_gradient,
  output logic [LANES-1:0]      acc_gradient_valid,
  output logic                  batch_done,
  output logic                  busy
);
  localparam int W = LANES * 32;
  logic [W-1:0] ram [2**DEPTH_BITS];
  logic [DEPTH_BITS-1:0] chunk_cnt, s1_addr, s2_addr, s3_addr;
  logic [15:0] sample_cnt, bs_m1;
  logic [DEPTH_BITS:0] nc_m1;
  logic chunk_wrap, s1_valid, s1_first, s1_last, s2_valid, s3_valid;
  logic [W-1:0] s1_grad, rd_data, partial, sum, scaled, s2_sum, s3_sum;
  logic signed [31:0] op_l, in_l, add_l;
  assign nc_m1 = (num_chunks == '0) ? '0 : num_chunks - (DEPTH_BITS+1)'(1);
  assign bs_m1 = (batch_size == '0) ? '0 : batch_size - 16'd1;
  assign chunk_wrap = {1'b0, chunk_cnt} == nc_m1;
  assign busy = s1_valid | s2_valid | s3_valid | (chunk_cnt != '0) | (sample_cnt != '0);
  // Newest in-flight sum wins; the RAM read is stale for the two most recent writes.
  always_comb begin
    partial = (s2_valid && s2_addr == s1_addr) ? s2_sum :
              (s3_valid && s3_addr == s1_addr) ? s3_sum : rd_data;
    sum = '0;
    scaled = '0;
    op_l = '0;
    in_l = '0;
    add_l = '0;
    for (int i = 0; i < LANES; i++) begin
      op_l = s1_first ? '0 : partial[i*32 +: 32];
      in_l = s1_grad[i*32 +: 32];
      add_l = op_l + in_l;
`ifdef SGD_ACC_SATURATE_EN
      add_l = (op_l[31] == in_l[31] && add_l[31] != op_l[31]) ?
              (op_l[31] ? 32'sh80000000 : 32'sh7fffffff) : add_l;
`endif
      sum[i*32 +: 32] = add_l;
      scaled[i*32 +: 32] = add_l >>> step_shift;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chunk_cnt <= '0;
      sample_cnt <= '0;
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
      acc_gradient <= '0;
      acc_gradient_valid <= '0;
      batch_done <= 1'b0;
    end else begin
      if (!started) begin
        chunk_cnt <= '0;
        sample_cnt <= '0;
      end else if (grad_valid) begin
        chunk_cnt <= chunk_wrap ? '0 : chunk_cnt + DEPTH_BITS'(1);
        if (chunk_wrap) sample_cnt <= (sample_cnt == bs_m1) ? '0 : sample_cnt + 16'd1;
      end
      s1_valid <= grad_valid && started;
      s2_valid <= s1_valid;
      s3_valid <= s2_valid;
      acc_gradient_valid <= {LANES{s1_valid && s1_last}};
      batch_done <= s1_valid && s1_last && ({1'b0, s1_addr} == nc_m1);
      if (s1_valid && s1_last) acc_gradient <= scaled;
    end
  end
  // Datapath and RAM carry no reset; valids qualify everything and first-sample beats overwrite.
  always_ff @(posedge clk) begin
    if (s2_valid) ram[s2_addr] <= s2_sum;
    rd_data <= ram[chunk_cnt];
    s1_addr <= chunk_cnt;
    s1_grad <= grad_in;
    s1_first <= sample_cnt == '0;
    s1_last <= sample_cnt == bs_m1;
    s2_addr <= s1_addr;
    s2_sum <= sum;
    s3_addr <= s2_addr;
    s3_sum <= s2_sum;
  end
endmodule

// File: tb/tb_sgd_gradient_batch_acc.sv
// tb_sgd_gradient_batch_acc: scoreboard bench for the mini-batch gradient accumulator.
module tb_sgd_gradient_batch_acc;
  localparam int L = 8;
  localparam int DB = 10;
  logic clk = 1'b0;
  logic rst_n, started, grad_valid, batch_done, busy;
  logic [DB:0] num_chunks;
  logic [15:0] batch_size;
  logic [4:0] step_shift;
  logic [L*32-1:0] grad_in, acc_gradient;
  logic [L-1:0] acc_gradient_valid;
  typedef struct {
    logic [L*32-1:0] d;
    logic done;
    logic [L-1:0] v;
    int cyc;
  } rec_t;
  rec_t expq[$];
  rec_t obs[$];
  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int sv[0:7][0:3];
  int macc[0:3][0:L-1];

  sgd_gradient_batch_acc #(.LANES(L), .DEPTH_BITS(DB)) dut (
    .clk(clk), .rst_n(rst_n), .started(started), .num_chunks(num_chunks),
    .batch_size(batch_size), .step_shift(step_shift), .grad_in(grad_in),
    .grad_valid(grad_valid), .acc_gradient(acc_gradient),
    .acc_gradient_valid(acc_gradient_valid), .batch_done(batch_done), .busy(busy));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1;
    if (acc_gradient_valid !== '0) obs.push_back('{acc_gradient, batch_done, acc_gradient_valid, cyc});
  end

  function automatic int madd(input int a, input int b);
`ifdef SGD_ACC_SATURATE_EN
    longint s = longint'(a) + longint'(b);
    return (s > 64'sd2147483647) ? 32'h7fffffff : (s < -64'sd2147483648) ? 32'h80000000 : int'(s);
`else
    return a + b;
`endif
  endfunction

  // Drives ns samples of a batch; expected outputs are pushed for last-sample beats only.
  task automatic drive_batch(input int nc, input int bs, input int ns, input int sh, input int gap, input int step);
    rec_t e;
    @(posedge clk); #1;
    started = 1'b0;
    grad_valid = 1'b0;
    num_chunks = (DB+1)'(nc);
    batch_size = 16'(bs);
    step_shift = 5'(sh);
    for (int s = 0; s < ns; s++)
      for (int c = 0; c < nc; c++) begin
        repeat ($urandom_range(0, gap)) begin @(posedge clk); #1; grad_valid = 1'b0; end
        @(posedge clk); #1;
        started = 1'b1;
        grad_valid = 1'b1;
        e.d = '0;
        for (int l = 0; l < L; l++) begin
          grad_in[l*32 +: 32] = sv[s][c] + l * step;
          macc[c][l] = (s == 0) ? sv[s][c] + l * step : madd(macc[c][l], sv[s][c] + l * step);
          e.d[l*32 +: 32] = macc[c][l] >>> sh;
        end
        e.done = (c == nc - 1);
        e.v = '1;
        e.cyc = cyc + 2;
        if (s == bs - 1) expq.push_back(e);
      end
    @(posedge clk); #1;
    grad_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    started = 1'b0;
    grad_valid = 1'b0;
    grad_in = '0;
    num_chunks = '0;
    batch_size = '0;
    step_shift = '0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (acc_gradient !== '0) begin n_fail++; $display("FAIL reset_acc_gradient: got %h, expected 0", acc_gradient); end
    n_cmp++; if (acc_gradient_valid !== '0) begin n_fail++; $display("FAIL reset_valid: got %h, expected 0", acc_gradient_valid); end
    n_cmp++; if (batch_done !== 1'b0) begin n_fail++; $display("FAIL reset_batch_done: got %b, expected 0", batch_done); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    rec_t o, e;
    for (int s = 0; s < 3; s++) for (int c = 0; c < 4; c++) sv[s][c] = c + 1;
    drive_batch(4, 3, 3, 0, 0, 0);
    repeat (8) @(posedge clk); #1;
    n_cmp++; if (obs.size() !== expq.size()) begin n_fail++; $display("FAIL basic_count: got %0d outputs, expected %0d", obs.size(), expq.size()); end
    while (obs.size() > 0 && expq.size() > 0) begin
      o = obs.pop_front(); e = expq.pop_front(); n_cmp++;
      if (o.d !== e.d || o.done !== e.done || o.v !== e.v || o.cyc !== e.cyc) begin
        n_fail++; $display("FAIL basic: got d=%h done=%b v=%h cyc=%0d, expected d=%h done=%b v=%h cyc=%0d", o.d, o.done, o.v, o.cyc, e.d, e.done, e.v, e.cyc);
      end
    end
    obs.delete(); expq.delete();
  endtask

  task automatic test_forwarding;
    rec_t o, e;
    for (int k = 0; k < 2; k++) begin
      for (int s = 0; s < 5; s++) for (int c = 0; c < 2; c++) sv[s][c] = (k == 0) ? 7 : c + 1;
      drive_batch(k + 1, 5, 5, 0, 0, 0);
      repeat (8) @(posedge clk); #1;
      n_cmp++; if (obs.size() !== expq.size()) begin n_fail++; $display("FAIL fwd%0d_count: got %0d outputs, expected %0d", k + 1, obs.size(), expq.size()); end
      while (obs.size() > 0 && expq.size() > 0) begin
        o = obs.pop_front(); e = expq.pop_front(); n_cmp++;
        if (o.d !== e.d || o.done !== e.done || o.v !== e.v || o.cyc !== e.cyc) begin
          n_fail++; $display("FAIL fwd%0d: got d=%h done=%b v=%h cyc=%0d, expected d=%h done=%b v=%h cyc=%0d", k + 1, o.d, o.done, o.v, o.cyc, e.d, e.done, e.v, e.cyc);
        end
      end
      obs.delete(); expq.delete();
    end
  endtask

  task automatic test_shift_overflow;
    rec_t o, e;
    for (int k = 0; k < 2; k++) begin
      sv[0][0] = (k == 0) ? -20 : 32'h7FFFFFF0;
      sv[1][0] = (k == 0) ? -4 : 32'h20;
      drive_batch(1, 2, 2, (k == 0) ? 3 : 0, 0, 0);
      repeat (8) @(posedge clk); #1;
      n_cmp++; if (obs.size() !== expq.size()) begin n_fail++; $display("FAIL arith%0d_count: got %0d outputs, expected %0d", k, obs.size(), expq.size()); end
      while (obs.size() > 0 && expq.size() > 0) begin
        o = obs.pop_front(); e = expq.pop_front(); n_cmp++;
        if (o.d !== e.d || o.done !== e.done || o.v !== e.v || o.cyc !== e.cyc) begin
          n_fail++; $display("FAIL arith%0d: got d=%h done=%b v=%h cyc=%0d, expected d=%h done=%b v=%h cyc=%0d", k, o.d, o.done, o.v, o.cyc, e.d, e.done, e.v, e.cyc);
        end
      end
      obs.delete(); expq.delete();
    end
  endtask

  task automatic test_gaps;
    rec_t o, e;
    for (int s = 0; s < 4; s++) for (int c = 0; c < 3; c++) sv[s][c] = int'($urandom_range(0, 2000)) - 1000;
    drive_batch(3, 4, 4, 1, 3, 5);
    repeat (8) @(posedge clk); #1;
    n_cmp++; if (obs.size() !== expq.size()) begin n_fail++; $display("FAIL gaps_count: got %0d outputs, expected %0d", obs.size(), expq.size()); end
    while (obs.size() > 0 && expq.size() > 0) begin
      o = obs.pop_front(); e = expq.pop_front(); n_cmp++;
      if (o.d !== e.d || o.done !== e.done || o.v !== e.v || o.cyc !== e.cyc) begin
        n_fail++; $display("FAIL gaps: got d=%h done=%b v=%h cyc=%0d, expected d=%h done=%b v=%h cyc=%0d", o.d, o.done, o.v, o.cyc, e.d, e.done, e.v, e.cyc);
      end
    end
    obs.delete(); expq.delete();
  endtask

  task automatic test_abort;
    rec_t o, e;
    for (int s = 0; s < 3; s++) for (int c = 0; c < 2; c++) sv[s][c] = 1000 + int'($urandom_range(0, 500));
    drive_batch(2, 3, 2, 0, 0, 3);
    started = 1'b0;
    repeat (3) @(posedge clk); #1;
    for (int s = 0; s < 3; s++) for (int c = 0; c < 2; c++) sv[s][c] = int'($urandom_range(0, 100)) - 50;
    drive_batch(2, 3, 3, 0, 1, 3);
    repeat (8) @(posedge clk); #1;
    n_cmp++; if (obs.size() !== expq.size()) begin n_fail++; $display("FAIL abort_count: got %0d outputs, expected %0d", obs.size(), expq.size()); end
    while (obs.size() > 0 && expq.size() > 0) begin
      o = obs.pop_front(); e = expq.pop_front(); n_cmp++;
      if (o.d !== e.d || o.done !== e.done || o.v !== e.v || o.cyc !== e.cyc) begin
        n_fail++; $display("FAIL abort: got d=%h done=%b v=%h cyc=%0d, expected d=%h done=%b v=%h cyc=%0d", o.d, o.done, o.v, o.cyc, e.d, e.done, e.v, e.cyc);
      end
    end
    obs.delete(); expq.delete();
  endtask

  task automatic test_reset_mid;
    rec_t o, e;
    for (int s = 0; s < 3; s++) for (int c = 0; c < 2; c++) sv[s][c] = 500 + int'($urandom_range(0, 500));
    drive_batch(2, 3, 2, 0, 0, 2);
    rst_n = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (acc_gradient !== '0) begin n_fail++; $display("FAIL midrst_acc_gradient: got %h, expected 0", acc_gradient); end
    n_cmp++; if (acc_gradient_valid !== '0) begin n_fail++; $display("FAIL midrst_valid: got %h, expected 0", acc_gradient_valid); end
    n_cmp++; if (batch_done !== 1'b0) begin n_fail++; $display("FAIL midrst_batch_done: got %b, expected 0", batch_done); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b, expected 0", busy); end
    rst_n = 1'b1;
    obs.delete(); expq.delete();
    for (int s = 0; s < 3; s++) for (int c = 0; c < 2; c++) sv[s][c] = int'($urandom_range(0, 300)) - 150;
    drive_batch(2, 3, 3, 1, 0, 2);
    repeat (8) @(posedge clk); #1;
    n_cmp++; if (obs.size() !== expq.size()) begin n_fail++; $display("FAIL midrst_count: got %0d outputs, expected %0d", obs.size(), expq.size()); end
    while (obs.size() > 0 && expq.size() > 0) begin
      o = obs.pop_front(); e = expq.pop_front(); n_cmp++;
      if (o.d !== e.d || o.done !== e.done || o.v !== e.v || o.cyc !== e.cyc) begin
        n_fail++; $display("FAIL midrst: got d=%h done=%b v=%h cyc=%0d, expected d=%h done=%b v=%h cyc=%0d", o.d, o.done, o.v, o.cyc, e.d, e.done, e.v, e.cyc);
      end
    end
    obs.delete(); expq.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_forwarding();
    test_shift_overflow();
    test_gaps();
    test_abort();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
